tile_board_mem: RTL and testbench
=================================

# tile_board_mem

Parametrised tile-board storage for the sliding-puzzle datapath. It holds DEPTH tiles of DW bits each and provides an asynchronous read port for display and solver logic. A single-write-port command interface supports WRITE, atomic two-cycle SWAP and multi-cycle CLEAR operations. A combinational `solved` flag reports when the board matches the identity pattern.

## Interface
- DW, 4, tile width in bits
- AW, 4, address width
- DEPTH, 16, number of tiles; DEPTH ≤ 2^AW, DEPTH ≥ 2
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  00 NOP, 01 WRITE, 10 SWAP, 11 CLEAR
- cmd_addr_a  in  AW  WRITE target / SWAP first tile
- cmd_addr_b  in  AW  SWAP second tile (ignored otherwise)
- cmd_wdata  in  DW  WRITE data
- rd_addr  in  AW  asynchronous read address
- rd_data  out  DW  mem[rd_addr], combinational; 0 when rd_addr ≥ DEPTH
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse with done when the command was rejected
- solved  out  1  combinational; 1 iff mem[i] == i[DW-1:0] for all i < DEPTH

## Operation
- Identity pattern: mem[i] = i truncated to DW bits.
- FSM states:
  - IDLE: cmd_ready=1.
  - SWAP2: cmd_ready=0.
  - CLR: cmd_ready=0, counter cnt of width AW.
- Accept = cmd_valid & cmd_ready; inputs are sampled only at the accept edge.
- NOP: no write; stays in IDLE.
- WRITE: mem[a] <= cmd_wdata at the accept edge; stays in IDLE.
- SWAP:
  - At the accept edge: tmp <= mem[a], mem[a] <= mem[b], latch b; go to SWAP2.
  - At the SWAP2 edge: mem[b] <= tmp; go to IDLE.
  - a == b is legal; contents end unchanged.
- CLEAR:
  - At the accept edge: mem[0] <= 0, cnt <= 1; go to CLR.
  - Each CLR edge: mem[cnt] <= cnt, cnt++.
  - The edge that writes DEPTH-1 returns to IDLE.
- Range check:
  - WRITE with a ≥ DEPTH, or SWAP with a or b ≥ DEPTH, is rejected.
  - A rejected command performs no write and stays in IDLE; done=err=1 on the following cycle.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold or retry.
- Only one write occurs per clock edge.

## Timing
- Reset (rst_n=0 at an edge): all mem entries <= identity pattern in one cycle, FSM <= IDLE, cnt <= 0, tmp <= 0, done <= 0, err <= 0.
- State immediately after reset: cmd_ready=1, solved=1, rd_data=rd_addr[DW-1:0] for in-range addresses.
- Reset mid-SWAP or mid-CLEAR aborts the operation; no done pulse is produced for it.
- done and err are registered. With accept edge T, the done cycle is:
  - NOP / WRITE / rejected command: done during cycle T+1.
  - SWAP: done during cycle T+2; cmd_ready=0 during T+1; a new command can be accepted at the T+2 edge.
  - CLEAR: done during cycle T+DEPTH-1; cmd_ready=0 during T+1 … T+DEPTH-1.
- Back-to-back WRITE/NOP: accepts every cycle; done is high on consecutive cycles.
- rd_data and solved reflect the array state after the most recent edge. A write at an edge becomes visible in the following cycle.
- Mid-SWAP the array is transiently inconsistent: after the first edge mem[a]==mem[b]. solved may glitch during SWAP2 and is valid once done is asserted.

## Test plan
- Reset, then read all addresses: rd_data=i for i=0..15; solved=1, cmd_ready=1, done=0.
- WRITE a=3, wdata=9: done in the next cycle, rd_data@3=9, solved=0. Then WRITE a=3, wdata=3: solved=1.
- SWAP a=14, b=15 on the identity board: cmd_ready=0 for one cycle, done at T+2. Then mem[14]=15, mem[15]=14, solved=0. Repeat the SWAP: solved=1.
- SWAP a=5, b=5: completes at T+2; mem[5]=5, no other entry changed.
- Scramble via WRITEs, then CLEAR: cmd_ready low for 15 cycles, done at T+15, all entries back to identity, solved=1. With DEPTH=9, AW=4, WRITE a=12: done=err=1, no entry changed, rd_data@12=0.
- Assert rst_n=0 during SWAP2: the next cycle shows the identity board, cmd_ready=1, and no done pulse. A cmd_valid pulse while cmd_ready=0 is not executed.

Source files
------------

// File: rtl/tile_board_mem.sv
// Tile-board storage for the sliding-puzzle datapath: async read port, single write port
// driven by a WRITE / two-cycle SWAP / multi-cycle CLEAR command FSM, plus a solved flag.
module tile_board_mem #(
    parameter int unsigned DW    = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic          solved
);

    localparam logic [1:0]    OP_NOP   = 2'b00;
    localparam logic [1:0]    OP_WRITE = 2'b01;
    localparam logic [1:0]    OP_SWAP  = 2'b10;
    localparam logic [1:0]    OP_CLEAR = 2'b11;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SWAP2,
        CLR
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] b_q, b_d;
    logic [DW-1:0] tmp_q, tmp_d;
    logic          done_d, err_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          accept, a_ok, b_ok, rd_ok;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign a_ok      = {1'b0, cmd_addr_a} < DEPTH_W;
    assign b_ok      = {1'b0, cmd_addr_b} < DEPTH_W;
    assign rd_ok     = {1'b0, rd_addr} < DEPTH_W;
    assign rd_data   = rd_ok ? mem[rd_addr] : '0;

    always_comb begin
        solved = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i] != DW'(i)) solved = 1'b0;
        end
    end

    // Next-state, single write-port control and completion pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: done_d = 1'b1;
                        OP_WRITE: begin
                            done_d = 1'b1;
                            if (a_ok) begin
                                wr_en   = 1'b1;
                                wr_addr = cmd_addr_a;
                                wr_data = cmd_wdata;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (a_ok && b_ok) begin
                                tmp_d   = mem[cmd_addr_a];
                                wr_en   = 1'b1;
                                wr_addr = cmd_addr_a;
                                wr_data = mem[cmd_addr_b];
                                b_d     = cmd_addr_b;
                                state_d = SWAP2;
                            end else begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            wr_en   = 1'b1;
                            cnt_d   = ONE;
                            state_d = CLR;
                            // done is raised for the last CLR cycle, not after it
                            done_d  = (LAST == ONE);
                        end
                        default: ;
                    endcase
                end
            end
            SWAP2: begin
                wr_en   = 1'b1;
                wr_addr = b_q;
                wr_data = tmp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            CLR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = DW'(cnt_q);
                cnt_d   = cnt_q + ONE;
                if (cnt_q == LAST) state_d = IDLE;
                else done_d = (cnt_d == LAST);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            tmp_q   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            tmp_q   <= tmp_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Board array: identity pattern on reset, at most one write per edge otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'(i);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_tile_board_mem.sv
// Bench for tile_board_mem: a 16-entry and a 9-entry board driven by the same command
// stream, checked against a command-level array model of the board.
`timescale 1ns/1ps
module tb_tile_board_mem;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a, cmd_addr_b, rd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rdy16, done16, err16, sol16;
    logic          rdy9, done9, err9, sol9;
    logic [DW-1:0] rd16, rd9;

    always #5 clk = ~clk;

    tile_board_mem #(.DW(DW), .AW(AW), .DEPTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy16),
        .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
        .cmd_wdata(cmd_wdata), .rd_addr(rd_addr), .rd_data(rd16),
        .done(done16), .err(err16), .solved(sol16)
    );

    tile_board_mem #(.DW(DW), .AW(AW), .DEPTH(9)) u9 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy9),
        .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
        .cmd_wdata(cmd_wdata), .rd_addr(rd_addr), .rd_data(rd9),
        .done(done9), .err(err9), .solved(sol9)
    );

    typedef struct {
        string name;
        int    op, a, b, wd;
        int    lat16, err16, lat9, err9;
    } vec_t;

    vec_t vecs[11];
    int   m16[16];
    int   m9[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rejected(input int depth, input int op, input int a, input int b);
        return (op == 1 && a >= depth) || (op == 2 && (a >= depth || b >= depth));
    endfunction

    function automatic int exp_lat(input int depth, input int op, input int a, input int b);
        if (rejected(depth, op, a, b)) return 1;
        if (op == 2) return 2;
        if (op == 3) return depth - 1;
        return 1;
    endfunction

    function automatic int exp_low(input int depth, input int op, input int a, input int b);
        if (rejected(depth, op, a, b)) return 0;
        if (op == 2) return 1;
        if (op == 3) return depth - 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m16[i] = i;
            m9[i]  = (i < 9) ? i : 0;
        end
    endtask

    task automatic model_apply(input int depth, input int op, input int a, input int b, input int wd);
        int m[16];
        int t;
        if (rejected(depth, op, a, b)) return;
        if (depth == 16) m = m16; else m = m9;
        case (op)
            1: m[a] = wd;
            2: begin t = m[a]; m[a] = m[b]; m[b] = t; end
            3: for (int i = 0; i < depth; i++) m[i] = i;
            default: ;
        endcase
        if (depth == 16) m16 = m; else m9 = m;
    endtask

    function automatic int model_solved(input int depth);
        for (int i = 0; i < depth; i++) begin
            if (depth == 16 && m16[i] != i) return 0;
            if (depth == 9 && m9[i] != i) return 0;
        end
        return 1;
    endfunction

    task automatic check_board(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i);
            #0.2;
            check($sformatf("%s rd16[%0d]", tag, i), int'(rd16), m16[i]);
            check($sformatf("%s rd9[%0d]", tag, i), int'(rd9), (i < 9) ? m9[i] : 0);
        end
        check({tag, " solved16"}, int'(sol16), model_solved(16));
        check({tag, " solved9"}, int'(sol9), model_solved(9));
    endtask

    task automatic run_cmd(input string tag, input int op, input int a, input int b, input int wd,
                           input int e_lat16, input int e_err16, input int e_lat9, input int e_err9);
        int l16, l9, lo16, lo9, p16, p9, er16, er9, mx;
        l16 = 0; l9 = 0; lo16 = 0; lo9 = 0; p16 = 0; p9 = 0; er16 = 0; er9 = 0;
        check({tag, " ready16 before"}, int'(rdy16), 1);
        check({tag, " ready9 before"}, int'(rdy9), 1);
        cmd_valid  = 1'b1;
        cmd_op     = 2'(op);
        cmd_addr_a = AW'(a);
        cmd_addr_b = AW'(b);
        cmd_wdata  = DW'(wd);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        for (int c = 1; c <= 40; c++) begin
            if (l16 == 0 && !rdy16) lo16++;
            if (l9 == 0 && !rdy9) lo9++;
            if (done16) begin
                p16++;
                if (l16 == 0) begin l16 = c; er16 = int'(err16); end
            end
            if (done9) begin
                p9++;
                if (l9 == 0) begin l9 = c; er9 = int'(err9); end
            end
            mx = (l16 > l9) ? l16 : l9;
            if (l16 != 0 && l9 != 0 && c > mx) break;
            tick();
        end
        check({tag, " latency16"}, l16, e_lat16);
        check({tag, " latency9"}, l9, e_lat9);
        check({tag, " err16"}, er16, e_err16);
        check({tag, " err9"}, er9, e_err9);
        check({tag, " busy16"}, lo16, exp_low(16, op, a, b));
        check({tag, " busy9"}, lo9, exp_low(9, op, a, b));
        check({tag, " pulses16"}, p16, 1);
        check({tag, " pulses9"}, p9, 1);
        model_apply(16, op, a, b, wd);
        model_apply(9, op, a, b, wd);
        check_board(tag);
    endtask

    initial begin
        vecs[0]  = '{"write3_9",   1,  3,  0,  9,  1, 0, 1, 0};
        vecs[1]  = '{"write3_3",   1,  3,  0,  3,  1, 0, 1, 0};
        vecs[2]  = '{"swap14_15",  2, 14, 15,  0,  2, 0, 1, 1};
        vecs[3]  = '{"swap14_15b", 2, 14, 15,  0,  2, 0, 1, 1};
        vecs[4]  = '{"swap5_5",    2,  5,  5,  0,  2, 0, 2, 0};
        vecs[5]  = '{"write12",    1, 12,  0,  7,  1, 0, 1, 1};
        vecs[6]  = '{"write0_15",  1,  0,  0, 15,  1, 0, 1, 0};
        vecs[7]  = '{"swap1_8",    2,  1,  8,  0,  2, 0, 2, 0};
        vecs[8]  = '{"swap2_11",   2,  2, 11,  0,  2, 0, 1, 1};
        vecs[9]  = '{"clear",      3,  0,  0,  0, 15, 0, 8, 0};
        vecs[10] = '{"nop",        0,  0,  0,  0,  1, 0, 1, 0};

        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = '0; cmd_addr_b = '0;
        cmd_wdata = '0; rd_addr = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        check("reset ready16", int'(rdy16), 1);
        check("reset ready9", int'(rdy9), 1);
        check("reset done16", int'(done16), 0);
        check("reset err9", int'(err9), 0);
        check_board("reset");

        foreach (vecs[i])
            run_cmd(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd,
                    vecs[i].lat16, vecs[i].err16, vecs[i].lat9, vecs[i].err9);

        // Back-to-back writes: accepted every cycle, done on consecutive cycles
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr_a = AW'(4); cmd_wdata = DW'(1);
        tick();
        check("b2b done16 #1", int'(done16), 1);
        check("b2b ready16 #1", int'(rdy16), 1);
        cmd_addr_a = AW'(5); cmd_wdata = DW'(9);
        tick();
        check("b2b done16 #2", int'(done16), 1);
        check("b2b done9 #2", int'(done9), 1);
        cmd_valid = 1'b0; cmd_op = 2'b00;
        tick();
        check("b2b done16 idle", int'(done16), 0);
        model_apply(16, 1, 4, 0, 1); model_apply(9, 1, 4, 0, 1);
        model_apply(16, 1, 5, 0, 9); model_apply(9, 1, 5, 0, 9);
        check_board("b2b");

        // A request presented during SWAP2 must not execute
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr_a = AW'(2); cmd_addr_b = AW'(3);
        tick();
        check("busy ready16", int'(rdy16), 0);
        cmd_op = 2'b01; cmd_addr_a = AW'(6); cmd_wdata = DW'(9);
        tick();
        check("busy swap done16", int'(done16), 1);
        cmd_valid = 1'b0; cmd_op = 2'b00;
        tick();
        check("busy done16 after", int'(done16), 0);
        model_apply(16, 2, 2, 3, 0); model_apply(9, 2, 2, 3, 0);
        check_board("ignored");

        // Reset during SWAP2 aborts the swap with no done pulse
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr_a = AW'(0); cmd_addr_b = AW'(4);
        tick();
        check("abort ready16 mid", int'(rdy16), 0);
        cmd_valid = 1'b0; cmd_op = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort done16", int'(done16), 0);
        check("abort done9", int'(done9), 0);
        check("abort ready16", int'(rdy16), 1);
        model_reset();
        check_board("abort");
        tick();
        check("abort done16 later", int'(done16), 0);

        for (int n = 0; n < 60; n++) begin
            int op, a, b, wd;
            op = int'($urandom_range(3, 0));
            if (op == 3 && $urandom_range(3, 0) != 0) op = 2;
            a  = int'($urandom_range(15, 0));
            b  = int'($urandom_range(15, 0));
            wd = int'($urandom_range(15, 0));
            run_cmd($sformatf("rnd%0d op%0d a%0d b%0d", n, op, a, b), op, a, b, wd,
                    exp_lat(16, op, a, b), int'(rejected(16, op, a, b)),
                    exp_lat(9, op, a, b), int'(rejected(9, op, a, b)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
